// File: rtl/weights_bank.sv
// Double-buffered MLP weight store: a valid/ready word stream fills the shadow bank, then an atomic swap makes it active.
// Latency: word written at its acceptance edge, swap visible 2 cycles after the last word; s_ready drops only in the SWAP cycle.
module weights_bank #(
    parameter int N1  = 98,
    parameter int N2  = 10,
    parameter int W_K = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [W_K-1:0]                      s_data,
    input  logic                                s_last,
    output logic [N1/2-1:0][N2-1:0][W_K-1:0]    weights_n1_mag,
    output logic [N1/2-1:0][N2-1:0][W_K-1:0]    weights_n1_pol,
    output logic [N2-1:0][W_K-1:0]              weights_n2,
    output logic                                bank_sel,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);
    localparam int R     = N1 / 2;
    localparam int TOTAL = N1 * N2 + N2;
    localparam int CNTW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int RW    = (R > 1) ? $clog2(R) : 1;
    localparam int CW    = (N2 > 1) ? $clog2(N2) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SWAP} state_t;
    typedef enum logic [1:0] {PH_MAG, PH_POL, PH_N2} phase_t;

    state_t          state;
    state_t          nxt;
    phase_t          phase;
    logic [CNTW-1:0] idx;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;

    logic [1:0][R-1:0][N2-1:0][W_K-1:0] mag_q;
    logic [1:0][R-1:0][N2-1:0][W_K-1:0] pol_q;
    logic [1:0][N2-1:0][W_K-1:0]        n2_q;

    logic acc;
    logic at_end;
    logic wr_en;
    logic err_set;
    logic err_clr;

    // Ready is held low while in reset so nothing is accepted before release.
    assign s_ready = rstn && (state != SWAP);
    assign acc     = s_valid && s_ready;
    assign at_end  = (idx == CNTW'(TOTAL - 1));
    assign wr_en   = acc && ((state == IDLE) || (state == LOAD));
    assign busy    = (state != IDLE);

    always_comb begin
        nxt     = state;
        err_set = 1'b0;
        err_clr = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (acc) begin
                    err_clr = (state == IDLE);
                    if (at_end) begin
                        nxt     = s_last ? SWAP : DRAIN;
                        err_set = !s_last;
                    end else if (s_last) begin
                        nxt     = IDLE;
                        err_set = 1'b1;
                    end else begin
                        nxt = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (acc && s_last) begin
                    nxt = IDLE;
                end
            end
            SWAP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_sel <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= (state == SWAP);
            if (state == SWAP) begin
                bank_sel <= ~bank_sel;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    // Address counters restart whenever the frame stops loading.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx   <= '0;
            phase <= PH_MAG;
            row   <= '0;
            col   <= '0;
        end else if (nxt != LOAD) begin
            idx   <= '0;
            phase <= PH_MAG;
            row   <= '0;
            col   <= '0;
        end else if (wr_en) begin
            idx <= idx + CNTW'(1);
            if (col == CW'(N2 - 1)) begin
                col <= '0;
                if (phase != PH_N2) begin
                    if (row == RW'(R - 1)) begin
                        row   <= '0;
                        phase <= (phase == PH_MAG) ? PH_POL : PH_N2;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mag_q <= '0;
            pol_q <= '0;
            n2_q  <= '0;
        end else if (wr_en) begin
            case (phase)
                PH_MAG:  mag_q[~bank_sel][row][col] <= s_data;
                PH_POL:  pol_q[~bank_sel][row][col] <= s_data;
                default: n2_q[~bank_sel][col]       <= s_data;
            endcase
        end
    end

    assign weights_n1_mag = mag_q[bank_sel];
    assign weights_n1_pol = pol_q[bank_sel];
    assign weights_n2     = n2_q[bank_sel];
endmodule

// File: tb/tb_weights_bank.sv
// Bench for weights_bank: small config (4/2/4) against a frame-level model, plus the default config spot check.
module tb_weights_bank;
    localparam int TOT  = 10;
    localparam int BTOT = 990;

    logic clk;
    logic rstn;

    logic                  s_valid, s_ready, s_last;
    logic [3:0]            s_data;
    logic [1:0][1:0][3:0]  mag, pol;
    logic [1:0][3:0]       n2;
    logic                  bank_sel, busy, done, err;

    logic                  b_valid, b_ready, b_last;
    logic [3:0]            b_data;
    logic [48:0][9:0][3:0] b_mag, b_pol;
    logic [9:0][3:0]       b_n2;
    logic                  b_bank, b_busy, b_done, b_err;

    weights_bank #(.N1(4), .N2(2), .W_K(4)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .weights_n1_mag(mag), .weights_n1_pol(pol), .weights_n2(n2),
        .bank_sel(bank_sel), .busy(busy), .done(done), .err(err)
    );

    weights_bank dut_big (
        .clk(clk), .rstn(rstn), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .s_last(b_last), .weights_n1_mag(b_mag), .weights_n1_pol(b_pol), .weights_n2(b_n2),
        .bank_sel(b_bank), .busy(b_busy), .done(b_done), .err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame-level reference model: words collect per frame, a full correctly
    // terminated frame becomes the active weights one stalled cycle later.
    int exp_w [TOT];
    int pend  [TOT];
    int fq    [$];
    bit draining;
    bit swap_pend;
    bit exp_bank, exp_done, exp_err, exp_busy;
    bit exp_ready = 1'b1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TOT; i++) exp_w[i] = 0;
            fq.delete();
            draining  = 0;
            swap_pend = 0;
            exp_bank  = 0;
            exp_done  = 0;
            exp_err   = 0;
            exp_busy  = 0;
            exp_ready = 1;
        end else begin
            exp_done = 0;
            if (swap_pend) begin
                exp_w     = pend;
                exp_bank  = !exp_bank;
                exp_done  = 1;
                swap_pend = 0;
                exp_ready = 1;
                exp_busy  = 0;
            end else if (s_valid && exp_ready) begin
                if (draining) begin
                    if (s_last) begin
                        draining = 0;
                        exp_busy = 0;
                    end
                end else begin
                    if (fq.size() == 0) exp_err = 0;
                    fq.push_back(int'(s_data));
                    if (fq.size() == TOT) begin
                        if (s_last) begin
                            for (int i = 0; i < TOT; i++) pend[i] = fq[i];
                            swap_pend = 1;
                            exp_ready = 0;
                        end else begin
                            exp_err  = 1;
                            draining = 1;
                        end
                        exp_busy = 1;
                        fq.delete();
                    end else if (s_last) begin
                        exp_err  = 1;
                        exp_busy = 0;
                        fq.delete();
                    end else begin
                        exp_busy = 1;
                    end
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", nm, got, want, $time);
        end
    endtask

    function automatic int sw(input int i);
        if (i < 4)      return int'(mag[i / 2][i % 2]);
        else if (i < 8) return int'(pol[(i - 4) / 2][(i - 4) % 2]);
        else            return int'(n2[i - 8]);
    endfunction

    function automatic int bw(input int i);
        if (i < 490)      return int'(b_mag[i / 10][i % 10]);
        else if (i < 980) return int'(b_pol[(i - 490) / 10][(i - 490) % 10]);
        else              return int'(b_n2[i - 980]);
    endfunction

    task automatic mon_check();
        int k;
        k = 0;
        chk("s_ready", s_ready, rstn ? exp_ready : 1'b0);
        chk("bank_sel", bank_sel, exp_bank);
        chk("done", done, exp_done);
        chk("err", err, exp_err);
        chk("busy", busy, exp_busy);
        for (int i = 0; i < TOT; i++) begin
            if (sw(i) != exp_w[i]) begin
                k = i;
                break;
            end
        end
        chk("weights", sw(k), exp_w[k]);
    endtask

    // One clock: check at the falling edge, return just after the rising edge.
    task automatic tick(output bit acc);
        @(negedge clk);
        mon_check();
        if (done === 1'b1) done_seen++;
        acc = rstn && s_valid && exp_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) tick(a);
    endtask

    task automatic send_word(input logic [3:0] d, input bit l, input bit gaps);
        bit a;
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                s_data  = 4'($urandom);
                s_last  = 1'($urandom);
                tick(a);
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        guard   = 0;
        a       = 0;
        while (!a && guard < 8) begin
            tick(a);
            guard++;
        end
        if (!a) chk("accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    typedef struct {
        int n;
        int base;
        int step;
        bit gaps;
        bit rnd;
        bit exp_swap;
        bit exp_err;
        bit exp_bank;
        int exp_mag00;
        int exp_n2_1;
    } frame_vec_t;

    frame_vec_t vecs [6];

    initial begin
        bit a;
        int d0;
        int k;

        vecs[0] = '{10,  1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1, 10};
        vecs[1] = '{10, 15, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 15,  6};
        vecs[2] = '{ 6,  3,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15,  6};
        vecs[3] = '{10,  2,  1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,  2, 11};
        vecs[4] = '{13,  4,  1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  2, 11};
        vecs[5] = '{10,  0,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  0,  0};

        s_valid = 0; s_data = 0; s_last = 0;
        b_valid = 0; b_data = 0; b_last = 0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(2);

        for (int v = 0; v < 6; v++) begin
            d0 = done_seen;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_word(vecs[v].rnd ? 4'($urandom) : 4'(vecs[v].base + vecs[v].step * i),
                          i == vecs[v].n - 1, vecs[v].gaps);
            end
            idle(4);
            chk("vec_swap", done_seen - d0, vecs[v].exp_swap);
            chk("vec_err", err, vecs[v].exp_err);
            chk("vec_bank", bank_sel, vecs[v].exp_bank);
            chk("vec_idle", busy, 0);
            if (!vecs[v].rnd) begin
                chk("vec_mag00", mag[0][0], vecs[v].exp_mag00);
                chk("vec_n2_1", n2[1], vecs[v].exp_n2_1);
            end
        end

        // Swap timing on an explicit frame: stall in t+1, new weights in t+2.
        for (int i = 0; i < 9; i++) send_word(4'(i + 1), 1'b0, 1'b0);
        s_valid = 1'b1; s_data = 4'd10; s_last = 1'b1;
        tick(a);
        s_valid = 1'b0; s_last = 1'b0;
        chk("t1_ready", s_ready, 0);
        chk("t1_done", done, 0);
        chk("t1_bank", bank_sel, 0);
        tick(a);
        chk("t2_done", done, 1);
        chk("t2_bank", bank_sel, 1);
        chk("t2_ready", s_ready, 1);
        chk("t2_pol11", pol[1][1], 8);
        chk("t2_n2_0", n2[0], 9);
        tick(a);
        chk("t3_done", done, 0);

        // Reset in the middle of a frame.
        d0 = done_seen;
        for (int i = 0; i < 5; i++) send_word(4'(i + 3), 1'b0, 1'b0);
        rstn = 1'b0;
        idle(2);
        chk("rst_bank", bank_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mag10", mag[1][0], 0);
        chk("rst_ready", s_ready, 0);
        rstn = 1'b1;
        idle(3);
        chk("rst_nodone", done_seen - d0, 0);
        chk("rst_ready_rel", s_ready, 1);

        // Default configuration, incrementing pattern modulo 16.
        chk("big_ready", b_ready, 1);
        for (int i = 0; i < BTOT; i++) begin
            b_valid = 1'b1;
            b_data  = 4'(i % 16);
            b_last  = (i == BTOT - 1);
            tick(a);
        end
        b_valid = 1'b0; b_last = 1'b0;
        chk("big_t1_ready", b_ready, 0);
        chk("big_t1_done", b_done, 0);
        tick(a);
        chk("big_done", b_done, 1);
        chk("big_bank", b_bank, 1);
        chk("big_err", b_err, 0);
        chk("big_mag48_9", b_mag[48][9], 9);
        chk("big_pol0_0", b_pol[0][0], 10);
        chk("big_n2_9", b_n2[9], 13);
        k = 0;
        for (int i = 0; i < BTOT; i++) begin
            if (bw(i) != i % 16) begin
                k = i;
                break;
            end
        end
        chk("big_weights", bw(k), k % 16);
        tick(a);
        chk("big_done_clr", b_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
